// File: rtl/crem_pkg.sv
// Shared definitions for the register-file command controller: opcodes and FSM states.
package crem_pkg;

    localparam logic [7:0] CMD_RF_WR = 8'hAA;
    localparam logic [7:0] CMD_RF_RD = 8'hBB;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_TX_SEND = 3'd5
    } crem_state_e;

endpackage

// File: rtl/reg_file_cmd_ctrl.sv
// Byte-stream command decoder driving the register file's WrEn/RdEn port.
// Frames: AA addr data (write), BB addr (read, one-byte response via tx_*).
module reg_file_cmd_ctrl
    import crem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int FRAME_TIMEOUT = 255,
    parameter int RD_TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] WrData,
    input  logic [DATA_WIDTH-1:0] RdData,
    input  logic                  RdData_Valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_busy,
    output logic                  cmd_err,
    output logic                  busy
);

    // One counter serves both timeouts, so size it for the larger one.
    localparam int TMO_MAX = (FRAME_TIMEOUT > RD_TIMEOUT) ? FRAME_TIMEOUT : RD_TIMEOUT;
    localparam int CNT_W   = $clog2(TMO_MAX + 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_TIMEOUT - 1);

    crem_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  cmd_err_q, cmd_err_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [7:0]            tx_data_q, tx_data_d;

    logic addr_bad;
    logic frame_tmo;
    logic rd_tmo;

    // Address bytes with any bit above the register file range are rejected.
    assign addr_bad  = (rx_data >> ADDR_WIDTH) != 8'h00;
    assign frame_tmo = (cnt_q == FRAME_LAST);
    assign rd_tmo    = (cnt_q == RD_LAST);

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;           // reload on entry to any state
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        cmd_err_d  = 1'b0;
        tx_valid_d = tx_valid_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        tx_data_d  = tx_data_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_RF_WR)      state_d = ST_WR_ADDR;
                    else if (rx_data == CMD_RF_RD) state_d = ST_RD_ADDR;
                    else                           cmd_err_d = 1'b1;
                end
            end
            ST_WR_ADDR, ST_RD_ADDR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (rx_valid) begin
                    if (addr_bad) begin
                        cmd_err_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        addr_d  = rx_data[ADDR_WIDTH-1:0];
                        cnt_d   = '0;
                        rd_en_d = (state_q == ST_RD_ADDR);
                        state_d = (state_q == ST_RD_ADDR) ? ST_RD_WAIT : ST_WR_DATA;
                    end
                end else if (frame_tmo) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (rx_valid) begin
                    wr_data_d = DATA_WIDTH'(rx_data);
                    wr_en_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (frame_tmo) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                // Bytes arriving here are dropped and do not reload the counter.
                cnt_d     = cnt_q + CNT_W'(1);
                rd_en_d   = 1'b1;
                cmd_err_d = rx_valid;
                if (RdData_Valid) begin
                    tx_data_d  = 8'(RdData);
                    tx_valid_d = 1'b1;
                    rd_en_d    = 1'b0;
                    state_d    = ST_TX_SEND;
                end else if (rd_tmo) begin
                    rd_en_d   = 1'b0;
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_TX_SEND: begin
                cmd_err_d = rx_valid;
                if (tx_valid_q && !tx_busy) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            tx_valid_q <= tx_valid_d;
            cmd_err_q  <= cmd_err_d;
            busy_q     <= busy_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign WrEn     = wr_en_q;
    assign RdEn     = rd_en_q;
    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;
    assign busy     = busy_q;
    assign address  = addr_q;
    assign WrData   = wr_data_q;
    assign tx_data  = tx_data_q;

endmodule

// File: doc/reg_file_cmd_ctrl.md
# reg_file_cmd_ctrl

Byte-stream command controller that drives the register file's initiator-side port. It takes framed command bytes from the receive path, decodes write and read commands, and issues single-cycle `WrEn` or held `RdEn` strobes to the register file. For reads it captures the returned `RdData` and hands it to the transmit path as a one-byte response.

## Interface
- `ADDR_WIDTH`, 4: register file address width; must be ≤ 8.
- `DATA_WIDTH`, 8: data byte width.
- `FRAME_TIMEOUT`, 255: maximum idle cycles allowed between bytes of one frame.
- `RD_TIMEOUT`, 15: maximum cycles to wait for `RdData_Valid`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle pulse; `rx_data` is valid.
- `WrEn` out 1: register file write strobe.
- `RdEn` out 1: register file read request.
- `address` out `ADDR_WIDTH`: register file address.
- `WrData` out `DATA_WIDTH`: register file write data.
- `RdData` in `DATA_WIDTH`: register file read data.
- `RdData_Valid` in 1: one-cycle pulse; `RdData` is valid.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: response byte is pending.
- `tx_busy` in 1: transmitter cannot accept a byte.
- `cmd_err` out 1: one-cycle error pulse.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Frame formats:
  - Write: `0xAA`, addr, data.
  - Read: `0xBB`, addr. The response is one byte, `RdData`.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
- IDLE, on `rx_valid`:
  - `0xAA` goes to WR_ADDR.
  - `0xBB` goes to RD_ADDR.
  - Any other byte pulses `cmd_err` and stays in IDLE.
- WR_ADDR / RD_ADDR, on `rx_valid`:
  - If `rx_data[7:ADDR_WIDTH]` is non-zero, pulse `cmd_err` and go to IDLE.
  - Otherwise latch `address` and go to WR_DATA or RD_WAIT respectively.
  - Entering RD_WAIT asserts `RdEn`.
- WR_DATA, on `rx_valid`: latch `WrData`, assert `WrEn` for exactly one cycle, go to IDLE.
- RD_WAIT:
  - `RdEn` stays high until `RdData_Valid` is seen.
  - On that cycle: capture `RdData` into `tx_data`, drop `RdEn`, set `tx_valid`, go to TX_SEND.
- TX_SEND: the byte is accepted on the first cycle with `tx_valid && !tx_busy`. On acceptance, clear `tx_valid` on the next edge and go to IDLE.
- Timeouts (one shared counter; reloads on state entry and on every accepted byte):
  - Frame: WR_ADDR, WR_DATA or RD_ADDR idle for `FRAME_TIMEOUT` cycles pulses `cmd_err` and returns to IDLE. No strobe is issued.
  - Read: RD_WAIT for `RD_TIMEOUT` cycles drops `RdEn`, pulses `cmd_err` and returns to IDLE. No response is sent.
- `rx_valid` during RD_WAIT or TX_SEND: the byte is dropped and `cmd_err` pulses. The current operation continues.
- `WrEn` and `RdEn` are never high in the same cycle.
- An `RdData_Valid` pulse outside RD_WAIT is ignored.
- Reset mid-operation aborts the frame. All outputs return to reset values immediately; no partial write is issued.

## Timing
- Reset values:
  - `WrEn`, `RdEn`, `tx_valid`, `cmd_err`, `busy`: 0.
  - `address`, `WrData`, `tx_data`: 0.
  - State: IDLE.
- All outputs are registered.
- Write: `WrEn` is high on the cycle after the data byte's `rx_valid`.
- Read: `RdEn` rises on the cycle after the addr byte's `rx_valid`. The register file returns `RdData_Valid` one cycle after it samples `RdEn`.
- Nominal read latency: `tx_valid` rises 3 cycles after the addr byte's `rx_valid`.
- `cmd_err` rises the cycle after the offending event.
- Back-to-back frames:
  - A new opcode is accepted in the cycle after the write strobe.
  - A new opcode is accepted in the cycle after the response is accepted.

## Structure
- Shared package `crem_pkg`:
  - Opcode constants `CMD_RF_WR` = 8'hAA and `CMD_RF_RD` = 8'hBB.
  - The FSM state enum.
- No sub-module: the FSM, timeout counter and output registers form one module.

## Test plan
- Write: send AA, 05, 3C. Required: `WrEn` high for 1 cycle with `address`=5 and `WrData`=0x3C; `busy` then returns to 0.
- Read: send BB, 05, with the model returning 0x3C. Required: `RdEn` held until `RdData_Valid`; `tx_data`=0x3C and `tx_valid` high 3 cycles after the addr byte. With `tx_busy` held 4 cycles, `tx_valid` stays high until accepted.
- Errors:
  - Opcode 0x55 gives one `cmd_err` pulse and no strobes.
  - Read address 0x1F with `ADDR_WIDTH`=4 gives `cmd_err` and no `RdEn`.
- Timeouts:
  - AA, 05 then silence gives `cmd_err` exactly `FRAME_TIMEOUT` cycles later and no `WrEn`.
  - Read with no `RdData_Valid` gives `cmd_err` after `RD_TIMEOUT` cycles with `RdEn` dropped.
- Reset: assert `rst` between the addr and data bytes of a write. Required: all outputs 0 and no write. After release, frame AA, 02, 81 writes correctly.
- Stray byte: send a byte during TX_SEND. Required: `cmd_err` pulses, the byte is dropped, and the pending response is still delivered intact.
